// File: rtl/approx_mult_pipe.sv
// Three-stage quadrant-decomposed approximate multiplier with valid/ready stream and per-quadrant modes.
// Define ERROR_STATS_EN to add exact-vs-approximate error statistics (err_sum, err_max, err_cnt).
module approx_mult_pipe #(
  parameter int         WIDTH    = 8,
  parameter logic [7:0] MODE_RST = 8'h00,
  parameter int         ERR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   R,
  output logic [7:0]           mode_q
`ifdef ERROR_STATS_EN
  ,
  output logic [ERR_W-1:0]     err_sum,
  output logic [2*WIDTH-1:0]   err_max,
  output logic [ERR_W-1:0]     err_cnt
`endif
);

  localparam int HW = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic                    w_adv;
  logic [7:0]              r_mode;

  logic                    r_s1_valid;
  logic [WIDTH-1:0]        r_s1_a;
  logic [WIDTH-1:0]        r_s1_b;
  logic [7:0]              r_s1_mode;

  logic                    r_s2_valid;
  logic [3:0][WIDTH-1:0]   r_s2_prod;
  logic [3:0][WIDTH-1:0]   w_prod;

  logic                    r_s3_valid;
  logic [PW-1:0]           r_s3_sum;
  logic [PW-1:0]           w_sum;

  // The whole pipeline moves as one; it only freezes when a result is stuck at the output.
  assign w_adv     = !r_s3_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_valid;
  assign R         = r_s3_sum;
  assign mode_q    = r_mode;

  // Quadrant gi: bit 1 selects the A half, bit 0 selects the B half (LL, LH, HL, HH).
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    logic [HW-1:0]    w_x;
    logic [HW-1:0]    w_y;
    logic [1:0]       w_m;
    logic [WIDTH-1:0] w_xe;
    logic [WIDTH-1:0] w_ye;
    logic [WIDTH-1:0] w_xs;
    logic [WIDTH-1:0] w_ys;
    logic [WIDTH-1:0] w_exact;

    assign w_x     = (gi / 2 == 1) ? r_s1_a[WIDTH-1:HW] : r_s1_a[HW-1:0];
    assign w_y     = (gi % 2 == 1) ? r_s1_b[WIDTH-1:HW] : r_s1_b[HW-1:0];
    assign w_m     = r_s1_mode[2*gi +: 2];
    assign w_xe    = {{HW{1'b0}}, w_x};
    assign w_ye    = {{HW{1'b0}}, w_y};
    assign w_xs    = {{HW{1'b0}}, w_x[HW-1:1], 1'b1};
    assign w_ys    = {{HW{1'b0}}, w_y[HW-1:1], 1'b1};
    assign w_exact = w_xe * w_ye;

    assign w_prod[gi] = (w_m == 2'b00) ? w_exact :
                        (w_m == 2'b01) ? w_xs * w_ys :
                        (w_m == 2'b10) ? {w_exact[WIDTH-1:HW], {HW{1'b0}}} :
                                         '0;
  end

  assign w_sum = {{WIDTH{1'b0}}, r_s2_prod[0]}
               + {{HW{1'b0}}, r_s2_prod[1], {HW{1'b0}}}
               + {{HW{1'b0}}, r_s2_prod[2], {HW{1'b0}}}
               + {r_s2_prod[3], {WIDTH{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_RST;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_sum   <= '0;
    end else begin
      if (cfg_we) begin
        r_mode <= cfg_mode;
      end
      if (w_adv) begin
        r_s1_valid <= in_valid;
        r_s2_valid <= r_s1_valid;
        r_s3_valid <= r_s2_valid;
        // Snapshot reads the pre-update register, so a same-edge cfg_we affects later operands only.
        if (in_valid) begin
          r_s1_a    <= A;
          r_s1_b    <= B;
          r_s1_mode <= r_mode;
        end
        if (r_s1_valid) begin
          r_s2_prod <= w_prod;
        end
        if (r_s2_valid) begin
          r_s3_sum <= w_sum;
        end
      end
    end
  end

`ifdef ERROR_STATS_EN
  localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;

  logic [PW-1:0]    r_s2_exact;
  logic [PW-1:0]    r_s3_exact;
  logic [ERR_W-1:0] r_err_sum;
  logic [PW-1:0]    r_err_max;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_fire;
  logic [PW-1:0]    w_err;
  logic [SW-1:0]    w_sum_ext;
  logic [ERR_W-1:0] w_sum_sat;

  assign w_fire    = r_s3_valid && out_ready;
  assign w_err     = (r_s3_exact >= r_s3_sum) ? (r_s3_exact - r_s3_sum) : (r_s3_sum - r_s3_exact);
  assign w_sum_ext = SW'(r_err_sum) + SW'(w_err);
  assign w_sum_sat = (|(w_sum_ext >> ERR_W)) ? {ERR_W{1'b1}} : w_sum_ext[ERR_W-1:0];

  assign err_sum = r_err_sum;
  assign err_max = r_err_max;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_exact <= '0;
      r_s3_exact <= '0;
    end else if (w_adv) begin
      if (r_s1_valid) begin
        r_s2_exact <= {{WIDTH{1'b0}}, r_s1_a} * {{WIDTH{1'b0}}, r_s1_b};
      end
      if (r_s2_valid) begin
        r_s3_exact <= r_s2_exact;
      end
    end
  end

  // A mode change starts a fresh measurement window.
  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      r_err_sum <= '0;
      r_err_max <= '0;
      r_err_cnt <= '0;
    end else if (w_fire) begin
      r_err_sum <= w_sum_sat;
      if (w_err > r_err_max) begin
        r_err_max <= w_err;
      end
      if (r_err_cnt != {ERR_W{1'b1}}) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: expected products queued at accept, compared at output handshake.
module tb_approx_mult_pipe;

  localparam int WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_we;
  logic [7:0]           cfg_mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   R;
  logic [7:0]           mode_q;
`ifdef ERROR_STATS_EN
  logic [31:0]          err_sum;
  logic [2*WIDTH-1:0]   err_max;
  logic [31:0]          err_cnt;
`endif

  int                   n_checks = 0;
  int                   n_pass   = 0;
  logic [15:0]          exp_q[$];
  logic [7:0]           tb_mode  = 8'h00;
  logic                 held_prev = 1'b0;
  logic [15:0]          held_r   = '0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.WIDTH(WIDTH), .MODE_RST(8'h00), .ERR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .mode_q    (mode_q)
`ifdef ERROR_STATS_EN
    ,
    .err_sum   (err_sum),
    .err_max   (err_max),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference product built arithmetically from nibble values.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int     xs[4];
    int     ys[4];
    int     sh[4];
    longint acc;
    int     p;
    xs = '{a % 16, a % 16, a / 16, a / 16};
    ys = '{b % 16, b / 16, b % 16, b / 16};
    sh = '{0, 4, 4, 8};
    acc = 0;
    for (int q = 0; q < 4; q++) begin
      case ((m >> (2 * q)) & 8'h3)
        8'h0:    p = xs[q] * ys[q];
        8'h1:    p = (xs[q] | 1) * (ys[q] | 1);
        8'h2:    p = (xs[q] * ys[q]) & ~15;
        default: p = 0;
      endcase
      acc += longint'(p) << sh[q];
    end
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_prev = 1'b0;
    end else begin
      if (held_prev) begin
        check("hold_R", R, held_r);
        check("hold_valid", out_valid, 1);
      end
      held_prev = out_valid && !out_ready;
      if (held_prev) begin
        held_r = R;
        check("in_ready_low", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else check("R", R, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, tb_mode));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    A = a;
    B = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic cfg(input logic [7:0] m);
    cfg_mode = m;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tb_mode = m;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; cfg_we = 1'b0; cfg_mode = 8'h00; in_valid = 1'b0;
    A = '0; B = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_R", R, 0);
    check("rst_mode_q", mode_q, 8'h00);
    check("rst_in_ready", in_ready, 1);

    // Latency: accept edge counts as edge 1.
    A = 8'd200; B = 8'd150; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 3);
    drain();

    cfg(8'h02); check("mode_q_02", mode_q, 8'h02);
    send(8'h0F, 8'h0F); drain();
    cfg(8'h01); send(8'h02, 8'h04); drain();
    cfg(8'hC0); send(8'hFF, 8'hFF); drain();

    cfg(8'($urandom));
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom));
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Same-edge cfg_we: this operand keeps the old (exact) mode.
    cfg(8'h00);
    A = 8'h0F; B = 8'h0F; in_valid = 1'b1; cfg_mode = 8'h02; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0; tb_mode = 8'h02;
    send(8'h0F, 8'h0F);
    drain();
    check("mode_q_after", mode_q, 8'h02);

    A = 8'h37; B = 8'h9A; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; tb_mode = 8'h00;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mode_q", mode_q, 8'h00);
    check("midrst_R", R, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (8) tick();
    send(8'h03, 8'h05); drain();

`ifdef ERROR_STATS_EN
    cfg(8'hC0);
    send(8'hFF, 8'hFF);
    send(8'h10, 8'h10);
    drain();
    check("err_cnt", err_cnt, 2);
    check("err_max", err_max, 57600);
    check("err_sum", err_sum, 57856);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
